// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned per request.
// Quotient and remainder are produced together behind valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | one quotient bit per cycle, MSB first
// DONE  | result held on the outputs until the consumer takes it
module div_iter #(
  parameter  int W  = 32,
  localparam int CW = $clog2(W) + 1
) (
  input  logic         phi,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_dvd;
  logic [W-1:0]    r_dvs;
  logic [W-2:0]    r_acc;
  logic [W-1:0]    r_quot;
  logic [W-1:0]    r_rem;
  logic            r_div_zero;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_accept;
  logic            w_b_zero;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_abs_a;
  logic [W-1:0]    w_abs_b;
  logic [W-1:0]    w_partial;
  logic            w_ge;
  logic [W-1:0]    w_acc_nxt;
  logic [W-1:0]    w_q_nxt;
  logic            w_last;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign quot      = r_quot;
  assign rem       = r_rem;
  assign div_zero  = r_div_zero;

  assign w_accept  = in_valid & in_ready;
  assign w_b_zero  = (b == '0);
  assign w_a_neg   = is_signed & a[W-1];
  assign w_b_neg   = is_signed & b[W-1];
  assign w_abs_a   = w_a_neg ? (~a + 1'b1) : a;
  assign w_abs_b   = w_b_neg ? (~b + 1'b1) : b;

  // The running remainder stays below 2^k after k steps, so its MSB can only be
  // set by the final subtraction; that last value goes straight to r_rem.
  assign w_partial = {r_acc, r_dvd[W-1]};
  assign w_ge      = (w_partial >= r_dvs);
  assign w_acc_nxt = w_ge ? (w_partial - r_dvs) : w_partial;
  assign w_q_nxt   = {r_dvd[W-2:0], w_ge};
  assign w_last    = (r_cnt == CW'(1));

  always_ff @(posedge phi or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_b_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge phi or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_acc      <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dvd   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_acc   <= '0;
            if (w_b_zero) begin
              // Divide by zero bypasses the iteration and reports the raw dividend.
              r_cnt      <= '0;
              r_quot     <= '1;
              r_rem      <= a;
              r_div_zero <= 1'b1;
            end else begin
              r_cnt <= CW'(W);
            end
          end
        end
        CALC: begin
          r_cnt <= r_cnt - 1'b1;
          r_acc <= w_acc_nxt[W-2:0];
          r_dvd <= w_q_nxt;
          if (w_last) begin
            r_quot     <= r_neg_q ? (~w_q_nxt + 1'b1) : w_q_nxt;
            r_rem      <= r_neg_r ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
            r_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
